// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   Serializes one DATA_WIDTH-bit word per frame onto an idle-high UART line:
//   start bit (0), data bits LSB first, optional even-parity bit, stop bit (1).
//   Each bit lasts exactly CLKS_PER_BIT enabled clock cycles, where
//   CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division, must be >= 2).
//
// Configuration macro:
//   UART_TX_PARITY_EN - when defined, a PARITY bit (XOR of the latched word,
//                       even parity) is sent between the last data bit and
//                       the stop bit. When undefined, the parity state and
//                       its logic are not built and DATA goes straight to STOP.
//
// Ports:
//   clk       in   1           rising-edge clock for all state
//   reset_n   in   1           asynchronous active-low reset
//   ena       in   1           global enable; low freezes every register
//   tx_data   in   DATA_WIDTH  word offered by the upstream FIFO
//   tx_valid  in   1           tx_data is valid this cycle
//   tx_ready  out  1           registered; word is taken when ena&valid&ready
//   tx        out  1           registered serial line, idle high
//   tx_busy   out  1           high whenever a frame is in progress
//   tx_done   out  1           one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]            state_reg,    state_next;
  logic [CNT_W-1:0]      baud_cnt_reg, baud_cnt_next;
  logic [IDX_W-1:0]      bit_idx_reg,  bit_idx_next;
  logic [DATA_WIDTH-1:0] shifter_reg,  shifter_next;
  logic                  tx_reg,       tx_next;
  logic                  tx_ready_reg, tx_ready_next;
  logic                  tx_done_reg,  tx_done_next;

  logic                  accept;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] shifted;

`ifdef UART_TX_PARITY_EN
  // Parity is captured at accept time because the shift register is
  // consumed while the data bits go out.
  logic                  parity_reg, parity_next;
  logic [DATA_WIDTH:0]   parity_chain;

  assign parity_chain[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_parity
      assign parity_chain[gi+1] = parity_chain[gi] ^ tx_data[gi];
    end
  endgenerate
`endif

  assign accept  = ena & tx_valid & tx_ready_reg;
  assign bit_end = (baud_cnt_reg == CNT_LAST);
  assign shifted = shifter_reg >> 1;

  // ---------------------------------------------------------------------------
  // Next-state logic. tx is computed one edge ahead so the line comes
  // straight from a flop and changes on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shifter_next  = shifter_reg;
    tx_next       = tx_reg;
    tx_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif

    // Ready is offered only from IDLE, and is withdrawn on the accept edge.
    // Coming out of STOP it therefore rises one cycle after tx_done.
    tx_ready_next = (state_reg == ST_IDLE) && !accept;

    // Baud counter runs in every non-idle state and wraps at bit end, which
    // also makes it zero on entry to the following state.
    if (state_reg != ST_IDLE) begin
      baud_cnt_next = bit_end ? '0 : baud_cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          state_next    = ST_START;
          shifter_next  = tx_data;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          tx_next       = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next   = parity_chain[DATA_WIDTH];
`endif
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          tx_next    = shifter_reg[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shifter_next = shifted;
          if (bit_idx_reg == IDX_LAST) begin
            bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = ST_PARITY;
            tx_next      = parity_reg;
`else
            state_next   = ST_STOP;
            tx_next      = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
            tx_next      = shifted[0];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          state_next   = ST_IDLE;
          tx_done_next = 1'b1;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        state_next    = ST_IDLE;
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        tx_next       = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. ena low freezes everything except tx_done, which is
  // cleared so a pulse can never stretch across a frozen period.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shifter_reg  <= '0;
      tx_reg       <= 1'b1;
      tx_ready_reg <= 1'b0;
      tx_done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else if (ena) begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shifter_reg  <= shifter_next;
      tx_reg       <= tx_next;
      tx_ready_reg <= tx_ready_next;
      tx_done_reg  <= tx_done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end else begin
      tx_done_reg  <= 1'b0;
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = tx_ready_reg;
  assign tx_busy  = (state_reg != ST_IDLE);
  // Gate so tx_done reads 0 for the whole of any cycle where ena is low.
  assign tx_done  = tx_done_reg & ena;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed self-checking bench for uart_tx_serializer with CLKS_PER_BIT = 4
// (1 MHz clock, 250 kbaud). Expected line levels are built from the frame
// format (start, data LSB first, optional even parity, stop) by the bench.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS   = 1 + DW + PAR + 1;
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic          clk;
  logic          reset_n;
  logic          ena;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int errors = 0;
  int checks = 0;

  uart_tx_serializer #(
    .DATA_WIDTH  (DW),
    .CLK_FREQ_HZ (1000000),
    .BAUD_RATE   (250000)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ena      (ena),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for frame bit position pos of word d.
  function automatic logic frame_bit(input logic [DW-1:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= DW) return d[pos-1];
    if (PAR == 1 && pos == DW + 1) return ^d;
    return 1'b1;
  endfunction

  // Called just after the accept edge. Checks ncycles cycles of the frame at
  // each falling edge; ena is dropped at the falling edge of cycle ps for pl
  // cycles (ps = 0 disables the pause).
  task automatic check_frame(input logic [DW-1:0] d, input int ps, input int pl,
                             input int ncycles, input string name);
    int en_edges;
    logic exp_tx;
    en_edges = 0;
    for (int k = 1; k <= ncycles; k++) begin
      @(negedge clk);
      if (k >= 2 && ena) en_edges++;
      if (ps != 0 && k == ps) ena = 1'b0;
      if (ps != 0 && k == ps + pl) ena = 1'b1;
      exp_tx = frame_bit(d, en_edges / CPB);
      checks++;
      if (tx !== exp_tx) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, tx, exp_tx);
      end
      checks++;
      if (tx_done !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s flags cycle %0d: got done=%b busy=%b ready=%b expected done=0 busy=1 ready=0",
                 name, k, tx_done, tx_busy, tx_ready);
      end
    end
  endtask

  // Two cycles after the final stop-bit edge: tx_done pulse, then ready.
  task automatic check_tail(input string name);
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s end: got done=%b tx=%b busy=%b ready=%b expected done=1 tx=1 busy=0 ready=0",
               name, tx_done, tx, tx_busy, tx_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after: got done=%b tx=%b ready=%b expected done=0 tx=1 ready=1",
               name, tx_done, tx, tx_ready);
    end
  endtask

  // Called at a falling edge with tx_ready expected high; returns 1 ns after
  // the accept edge. hold keeps tx_valid asserted afterwards with hold_data.
  task automatic do_accept(input logic [DW-1:0] d, input logic hold,
                           input logic [DW-1:0] hold_data, input string name);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready before accept: got %b expected 1", name, tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) tx_data = hold_data;
    else      tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    ena      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tx=%b ready=%b busy=%b done=%b expected 1 0 0 0",
               tx, tx_ready, tx_busy, tx_done);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b tx=%b busy=%b expected 1 1 0",
               tx_ready, tx, tx_busy);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                 i, tx, tx_ready, tx_busy, tx_done);
      end
    end
    $display("test_reset: reset and 100 idle cycles checked");
  endtask

  task automatic test_frame(input logic [DW-1:0] d);
    do_accept(d, 1'b0, '0, "frame");
    check_frame(d, 0, 0, FRAME_CYCLES, "frame");
    check_tail("frame");
    $display("test_frame: word 0x%02h sent in %0d cycles", d, FRAME_CYCLES);
  endtask

  task automatic test_back_to_back;
    do_accept(8'h55, 1'b1, 8'hFF, "b2b_first");
    check_frame(8'h55, 0, 0, FRAME_CYCLES, "b2b_first");
    // Cycle after stop-bit end: done pulse, ready still low, 0xFF waiting.
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b1 || tx_ready !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap1: got done=%b ready=%b tx=%b expected 1 0 1", tx_done, tx_ready, tx);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || tx_ready !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap2: got done=%b ready=%b tx=%b busy=%b expected 0 1 1 0",
               tx_done, tx_ready, tx, tx_busy);
    end
    // tx_valid is still high, so this edge is the accept of 0xFF.
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_frame(8'hFF, 0, 0, FRAME_CYCLES, "b2b_second");
    check_tail("b2b_second");
    $display("test_back_to_back: 0x55 then 0xFF with 2-cycle gap checked");
  endtask

  task automatic test_ena_pause;
    // Data bit 3 spans cycles 17..20; freeze from cycle 18 for 10 cycles.
    do_accept(8'h3C, 1'b0, '0, "ena_pause");
    check_frame(8'h3C, 18, 10, FRAME_CYCLES + 10, "ena_pause");
    check_tail("ena_pause");
    $display("test_ena_pause: 0x3C with 10-cycle freeze in %0d cycles", FRAME_CYCLES + 10);
  endtask

  task automatic test_reset_mid_frame;
    // Data bit 5 (tx=1) spans cycles 25..28; bit 4 gives tx=1, bits 0..3 tx=0.
    do_accept(8'hF0, 1'b0, '0, "mid_reset");
    check_frame(8'hF0, 0, 0, 26, "mid_reset");
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got tx=%b busy=%b ready=%b done=%b expected 1 0 0 0",
               tx, tx_busy, tx_ready, tx_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx_done !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_hold %0d: got done=%b tx=%b ready=%b expected 0 1 0",
                 i, tx_done, tx, tx_ready);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got ready=%b tx=%b busy=%b done=%b expected 1 1 0 0",
               tx_ready, tx, tx_busy, tx_done);
    end
    $display("test_reset_mid_frame: 0xF0 aborted in data bit 5");
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_back_to_back();
    test_ena_pause();
    test_reset_mid_frame();
    test_frame(8'h80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame.
REQ-002 Parameter CLK_FREQ_HZ, default 50000000: clk frequency.
REQ-003 Parameter BAUD_RATE, default 115200: line bit rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, integer truncation; must be >= 2.
REQ-004 The port list SHALL be as follows:
- clk, input, 1: single clock; all state rising-edge.
- reset_n, input, 1: asynchronous active-low reset.
- ena, input, 1: global enable; low freezes all state.
- tx_data, input, DATA_WIDTH: byte from upstream FIFO.
- tx_valid, input, 1: tx_data valid this cycle.
- tx_ready, output, 1: serializer can accept a byte this cycle.
- tx, output, 1: serial line; idle high.
- tx_busy, output, 1: frame in progress.
- tx_done, output, 1: one-cycle pulse at end of stop bit.

Function
REQ-005 The serializer SHALL implement an FSM with states IDLE, START, DATA, PARITY (macro-gated) and STOP.
REQ-006 tx_ready SHALL be registered, and high only in IDLE with no accept occurring in the same cycle.
REQ-007 An accept SHALL occur when ena, tx_valid and tx_ready are all high; on accept the serializer SHALL latch tx_data into its shift register and go to START on the next edge.
- tx_ready SHALL drop the cycle after an accept.
REQ-008 tx_valid SHALL be ignored while tx_ready is low; no byte is buffered or lost-tracked.
- The upstream FIFO must only pulse tx_valid after sampling tx_ready high.
REQ-009 A baud counter SHALL count 0..CLKS_PER_BIT-1, then wrap to 0 and end the current bit.
- The counter SHALL reset to 0 on every state entry.
- Each bit SHALL be exactly CLKS_PER_BIT enabled cycles.
REQ-010 Line levels per state:
- START: tx=0.
- DATA: tx=shift_reg[0], LSB first; shift right at each bit end.
- A bit index counts 0..DATA_WIDTH-1, and the last bit end goes to PARITY or STOP.
REQ-011 STOP: tx=1 for one bit. At bit end:
- tx_done pulses high for exactly one cycle.
- The FSM returns to IDLE.
- tx_ready rises the following cycle.
REQ-012 tx SHALL be driven from a register (glitch-free) and be 1 in IDLE.
REQ-013 tx_busy SHALL be high in every state except IDLE.
REQ-014 With ena low, the FSM, baud counter, bit index and shift register SHALL hold, and tx SHALL hold its current level.
- tx_done SHALL be 0 while ena is low.
- An accept cannot occur while ena is low.
REQ-015 Back-to-back frames: minimum gap stop-bit-end to next start bit = 1 cycle (IDLE) plus the accept cycle; there is no extra idle bit.

Reset
REQ-016 reset_n low SHALL asynchronously set the following, regardless of ena or frame position:
- FSM=IDLE; tx=1, tx_ready=0, tx_busy=0, tx_done=0.
- Counters and shift register = 0.
REQ-017 tx_ready SHALL go high on the first enabled clk edge after reset_n deasserts.
REQ-018 Reset mid-frame SHALL abort the frame with no tx_done; the line returns high immediately.

Configuration
REQ-019 Macro UART_TX_PARITY_EN:
- Defined: a PARITY state follows DATA for one bit with tx = XOR of the latched byte (even parity); the frame is 1+DATA_WIDTH+1+1 bits.
- Undefined: the PARITY state and its logic are absent, DATA goes directly to STOP, and the frame is 1+DATA_WIDTH+1 bits.

Verification (CLK_FREQ_HZ=1000000, BAUD_RATE=250000, so CLKS_PER_BIT=4)
REQ-020 Reset release, tx_valid=0: tx=1, tx_busy=0, tx_ready=1 from the first edge; no toggling for 100 cycles.
REQ-021 Accept 0xA5 without the macro:
- tx sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
- tx_done pulses once at cycle 40 after accept+1.
- tx_ready=0 throughout, and 1 after.
REQ-022 Same with UART_TX_PARITY_EN, 0x07: bits 0,1,1,1,0,0,0,0,0, parity=1, stop=1; 44 cycles total.
REQ-023 Accept 0x55, then hold tx_valid=1 with 0xFF during the frame: 0xFF is not captured until tx_ready returns; second frame starts 2 cycles after the first stop-bit end.
REQ-024 Drop ena for 10 cycles during data bit 3 of 0x3C: tx holds level, frame resumes, and total frame = 40+10 cycles.
REQ-025 Assert reset_n=0 during data bit 5 of 0xF0: tx=1 within the same cycle (async), no tx_done, and tx_ready=1 one cycle after release.
